// File: rtl/conv_output_buffer.sv
`default_nettype none
// ============================================================================
// Module   : conv_output_buffer
// Purpose  : Elastic output stage for the convolution pixel stream. Buffers
//            one 8-bit pixel per cycle in a show-ahead FIFO and drains it to
//            the consumer under a valid/ready handshake. Tracks the output
//            column/row of the head pixel to flag end-of-line / end-of-frame,
//            and raises almost_full so the source can throttle in time.
// Ports    : clk                  - rising-edge clock
//            reset                - asynchronous active-low reset
//            in_pixel_data        - convolved pixel in
//            in_pixel_data_valid  - write strobe (no backpressure)
//            out_pixel_data       - pixel at FIFO head
//            out_pixel_data_valid - FIFO non-empty
//            out_ready            - consumer accepts head this cycle
//            out_eol / out_eof    - head is last pixel of line / frame
//            almost_full          - throttle request to upstream
//            overflow             - sticky: a pixel was dropped
//            fill_count           - occupancy 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module conv_output_buffer #(
    parameter int DEPTH       = 256,
    parameter int LINE_WIDTH  = 126,
    parameter int NUM_LINES   = 126,
    parameter int AFULL_LEVEL = 240
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               in_pixel_data,
    input  logic                     in_pixel_data_valid,
    output logic [7:0]               out_pixel_data,
    output logic                     out_pixel_data_valid,
    input  logic                     out_ready,
    output logic                     out_eol,
    output logic                     out_eof,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fill_count
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CW    = c_AW + 1;
    localparam int c_COL_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int c_ROW_W = (NUM_LINES  > 1) ? $clog2(NUM_LINES)  : 1;

    localparam logic [c_CW-1:0]    c_FULL     = c_CW'(DEPTH);
    localparam logic [c_CW-1:0]    c_AFULL    = c_CW'(AFULL_LEVEL);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(LINE_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(NUM_LINES - 1);

    logic [7:0]         r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CW-1:0]    r_count;
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic               r_afull;
    logic               r_overflow;

    logic               w_valid;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_col_last;
    logic               w_row_last;
    logic [c_CW-1:0]    w_count_nxt;

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == c_FULL);
    assign w_pop   = w_valid & out_ready;
    // A full FIFO still accepts a pixel when the head leaves in the same cycle.
    assign w_push  = in_pixel_data_valid & (~w_full | w_pop);

    assign w_col_last = (r_col == c_COL_LAST);
    assign w_row_last = (r_row == c_ROW_LAST);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Storage carries no reset; validity is governed entirely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_pixel_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_afull    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            r_count <= w_count_nxt;
            // Registered from the next count so it changes on the same edge
            // as fill_count.
            r_afull <= (w_count_nxt >= c_AFULL);
            if (in_pixel_data_valid && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign out_pixel_data       = r_mem[r_rd_ptr];
    assign out_pixel_data_valid = w_valid;
    assign out_eol              = w_valid & w_col_last;
    assign out_eof              = w_valid & w_col_last & w_row_last;
    assign almost_full          = r_afull;
    assign overflow             = r_overflow;
    assign fill_count           = r_count;

endmodule
`default_nettype wire

// File: tb/tb_conv_output_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_output_buffer
// Purpose  : Directed self-checking bench for conv_output_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_output_buffer;

    localparam int c_N = 126 * 126;

    logic       clk;
    logic       reset;
    logic [7:0] in_pixel_data;
    logic       in_pixel_data_valid;
    logic [7:0] out_pixel_data;
    logic       out_pixel_data_valid;
    logic       out_ready;
    logic       out_eol;
    logic       out_eof;
    logic       almost_full;
    logic       overflow;
    logic [8:0] fill_count;

    int total = 0;
    int bad   = 0;

    conv_output_buffer #(
        .DEPTH       (256),
        .LINE_WIDTH  (126),
        .NUM_LINES   (126),
        .AFULL_LEVEL (240)
    ) u_dut (
        .clk                  (clk),
        .reset                (reset),
        .in_pixel_data        (in_pixel_data),
        .in_pixel_data_valid  (in_pixel_data_valid),
        .out_pixel_data       (out_pixel_data),
        .out_pixel_data_valid (out_pixel_data_valid),
        .out_ready            (out_ready),
        .out_eol              (out_eol),
        .out_eof              (out_eof),
        .almost_full          (almost_full),
        .overflow             (overflow),
        .fill_count           (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pushed;
        int pops;
        int eolc;
        int eofc;
        int eofpos;
        int derr;
        int perr;
        int ncyc;

        reset               = 1'b0;
        in_pixel_data       = 8'h00;
        in_pixel_data_valid = 1'b0;
        out_ready           = 1'b0;
        cyc();
        cyc();

        // Reset values
        chk("rst_fill",  fill_count, 0);
        chk("rst_valid", out_pixel_data_valid, 0);
        chk("rst_eol",   out_eol, 0);
        chk("rst_eof",   out_eof, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_ovf",   overflow, 0);
        reset = 1'b1;

        // Five pushes with consumer stalled, then drain
        for (int i = 0; i < 5; i++) begin
            in_pixel_data       = 8'h10 + 8'(i);
            in_pixel_data_valid = 1'b1;
            cyc();
            if (i == 0) begin
                chk("lat_valid", out_pixel_data_valid, 1);
                chk("lat_data",  out_pixel_data, 8'h10);
            end
        end
        in_pixel_data_valid = 1'b0;
        chk("five_fill", fill_count, 5);
        chk("five_head", out_pixel_data, 8'h10);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_data", out_pixel_data, 8'h10 + 8'(i));
            cyc();
        end
        chk("drain_valid", out_pixel_data_valid, 0);
        chk("drain_fill",  fill_count, 0);

        // Steady-state push and pop every cycle
        for (int i = 0; i < 8; i++) begin
            in_pixel_data       = 8'h20 + 8'(i);
            in_pixel_data_valid = 1'b1;
            cyc();
            chk("steady_fill", fill_count, 1);
            chk("steady_data", out_pixel_data, 8'h20 + 8'(i));
        end
        in_pixel_data_valid = 1'b0;
        cyc();
        chk("steady_end", out_pixel_data_valid, 0);

        // Asynchronous reset mid-line with 37 pixels buffered
        out_ready = 1'b0;
        for (int i = 0; i < 37; i++) begin
            in_pixel_data       = 8'h40 + 8'(i);
            in_pixel_data_valid = 1'b1;
            cyc();
        end
        in_pixel_data_valid = 1'b0;
        chk("pre_arst_fill", fill_count, 37);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_fill",  fill_count, 0);
        chk("arst_valid", out_pixel_data_valid, 0);
        chk("arst_eol",   out_eol, 0);
        chk("arst_afull", almost_full, 0);
        cyc();
        reset = 1'b1;

        // One full frame with random consumer stalls, source throttled by almost_full
        pushed = 0; pops = 0; eolc = 0; eofc = 0; eofpos = 0; derr = 0; perr = 0; ncyc = 0;
        while (pops < c_N && ncyc < 40000) begin
            in_pixel_data_valid = (pushed < c_N) && !almost_full;
            in_pixel_data       = pushed[7:0];
            out_ready           = ($urandom_range(0, 3) != 0);
            if (out_pixel_data_valid && out_ready) begin
                if (out_pixel_data !== pops[7:0]) derr++;
                if (out_eol !== ((pops % 126) == 125)) perr++;
                if (out_eof !== (pops == c_N - 1)) perr++;
                if (out_eol) eolc++;
                if (out_eof) begin
                    eofc++;
                    eofpos = pops + 1;
                end
                pops++;
            end
            if (in_pixel_data_valid) pushed++;
            cyc();
            ncyc++;
        end
        in_pixel_data_valid = 1'b0;
        out_ready           = 1'b0;
        chk("frame_pops",   pops, c_N);
        chk("frame_data",   derr, 0);
        chk("frame_marks",  perr, 0);
        chk("frame_eolcnt", eolc, 126);
        chk("frame_eofcnt", eofc, 1);
        chk("frame_eofpos", eofpos, c_N);
        chk("frame_ovf",    overflow, 0);
        chk("frame_empty",  out_pixel_data_valid, 0);

        // Stall on a line's last pixel; counters must be back at row 0, col 0
        for (int i = 0; i < 126; i++) begin
            in_pixel_data       = 8'(i);
            in_pixel_data_valid = 1'b1;
            cyc();
        end
        in_pixel_data_valid = 1'b0;
        chk("stall_first_eol", out_eol, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 125; i++) cyc();
        out_ready = 1'b0;
        chk("stall_fill", fill_count, 1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_data", out_pixel_data, 8'd125);
            chk("stall_eol",  out_eol, 1);
            chk("stall_eof",  out_eof, 0);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        chk("stall_pop_valid", out_pixel_data_valid, 0);
        chk("stall_pop_eol",   out_eol, 0);
        out_ready = 1'b0;

        // Fill to full, almost_full threshold, concurrent push/pop at full, drop
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_pixel_data       = 8'(i);
            in_pixel_data_valid = 1'b1;
            cyc();
            if (i == 238) chk("afull_239", almost_full, 0);
            if (i == 239) begin
                chk("afull_240", almost_full, 1);
                chk("fill_240",  fill_count, 240);
            end
        end
        chk("full_fill", fill_count, 256);
        chk("full_ovf",  overflow, 0);
        in_pixel_data = 8'hBB;
        out_ready     = 1'b1;
        cyc();
        chk("full_pp_fill", fill_count, 256);
        chk("full_pp_ovf",  overflow, 0);
        chk("full_pp_head", out_pixel_data, 8'h01);
        in_pixel_data = 8'hCC;
        out_ready     = 1'b0;
        cyc();
        chk("drop_ovf",  overflow, 1);
        chk("drop_fill", fill_count, 256);
        in_pixel_data_valid = 1'b0;
        out_ready           = 1'b1;
        derr = 0;
        for (int i = 0; i < 256; i++) begin
            if (out_pixel_data !== ((i < 255) ? 8'(i + 1) : 8'hBB)) derr++;
            cyc();
        end
        chk("full_drain_data", derr, 0);
        chk("full_drain_valid", out_pixel_data_valid, 0);
        chk("ovf_sticky", overflow, 1);
        chk("afull_clear", almost_full, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
